// File: rtl/fc_lane_serializer.sv
// Captures NUM_CH parallel lanes in one transfer, then streams the enabled lanes
// in ascending order on a valid/ready port, tagged with a 1-based channel index.
module fc_lane_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CH     = 8,
  localparam int unsigned CH_W      = $clog2(NUM_CH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_mask,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         done
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e                       state_q, state_d;
  logic [NUM_CH*DATA_WIDTH-1:0] hold_q, hold_d;
  logic [NUM_CH-1:0]            rem_q, rem_d;
  logic                         done_q, done_d;

  logic [NUM_CH-1:0] rem_clr;
  logic [IDX_W-1:0]  cur_idx;
  logic              cur_last;
  logic              send;
  logic              accept;

  // Lowest remaining lane; scanning downward lets the lowest set bit win.
  always_comb begin
    cur_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rem_q[i]) cur_idx = IDX_W'(i);
    end
  end

  assign rem_clr  = rem_q & (rem_q - NUM_CH'(1));
  assign cur_last = (rem_q != '0) && (rem_clr == '0);
  assign send     = (state_q == SEND);

  assign out_valid = send;
  assign out_last  = send & cur_last;
  assign out_ch    = send ? (CH_W'(cur_idx) + CH_W'(1)) : '0;
  assign out_data  = send ? hold_q[32'(cur_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign done      = done_q;

  // A new frame may enter only while idle or on the final beat of the current one.
  assign in_ready = send ? (out_ready & cur_last) : 1'b1;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d = in_data;
          rem_d  = in_mask;
          if (in_mask != '0) state_d = SEND;
          else               done_d  = 1'b1;
        end
      end
      SEND: begin
        if (out_ready) begin
          rem_d = rem_clr;
          if (cur_last) begin
            done_d = 1'b1;
            if (accept) begin
              hold_d  = in_data;
              rem_d   = in_mask;
              state_d = (in_mask != '0) ? SEND : IDLE;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_fc_lane_serializer.sv
// Directed bench for fc_lane_serializer: an 8x16 instance and a 5x12 instance.
module tb_fc_lane_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] in_data;
  logic [7:0]   in_mask;
  logic         in_valid, in_ready;
  logic [15:0]  out_data;
  logic [3:0]   out_ch;
  logic         out_last, out_valid, out_ready, done;

  logic         rst5;
  logic [59:0]  in_data5;
  logic [4:0]   in_mask5;
  logic         in_valid5, in_ready5;
  logic [11:0]  out_data5;
  logic [2:0]   out_ch5;
  logic         out_last5, out_valid5, out_ready5, done5;

  fc_lane_serializer #(.DATA_WIDTH(16), .NUM_CH(8)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_mask(in_mask),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .done(done)
  );

  fc_lane_serializer #(.DATA_WIDTH(12), .NUM_CH(5)) u_dut5 (
    .clk(clk), .rst(rst5), .in_data(in_data5), .in_mask(in_mask5),
    .in_valid(in_valid5), .in_ready(in_ready5), .out_data(out_data5),
    .out_ch(out_ch5), .out_last(out_last5), .out_valid(out_valid5),
    .out_ready(out_ready5), .done(done5)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int k = 1; k <= 8; k++) in_data[(k-1)*16 +: 16] = 16'(k << 8);
  endtask

  task automatic check_beat(input string tag, input int ch, input logic last);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " ch"},    32'(out_ch),    32'(ch));
    check({tag, " data"},  32'(out_data),  32'(ch << 8));
    check({tag, " last"},  32'(out_last),  32'(last));
  endtask

  int exp_ch[3] = '{3, 6, 8};

  initial begin
    rst = 1'b1; in_data = '0; in_mask = '0; in_valid = 1'b0; out_ready = 1'b0;
    rst5 = 1'b1; in_data5 = '0; in_mask5 = '0; in_valid5 = 1'b0; out_ready5 = 1'b0;
    tick(); tick();
    rst = 1'b0; rst5 = 1'b0;

    // Reset state
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst ch",    32'(out_ch),    32'd0);
    check("rst data",  32'(out_data),  32'd0);
    check("rst last",  32'(out_last),  32'd0);
    check("rst done",  32'(done),      32'd0);
    check("rst ready", 32'(in_ready),  32'd1);

    // Full mask, no stalls
    load_ramp(); in_mask = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check_beat("full", k, k == 8);
      check("full done", 32'(done), 32'd0);
      tick();
    end
    check("full idle valid", 32'(out_valid), 32'd0);
    check("full done pulse", 32'(done), 32'd1);
    tick();
    check("full done clear", 32'(done), 32'd0);

    // Sparse mask with alternating stalls
    in_mask = 8'hA4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      out_ready = 1'b0;
      check_beat("sparse stall", exp_ch[b], b == 2);
      tick();
      out_ready = 1'b1;
      check_beat("sparse go", exp_ch[b], b == 2);
      tick();
    end
    check("sparse end valid", 32'(out_valid), 32'd0);
    check("sparse done", 32'(done), 32'd1);
    tick();

    // Empty mask
    in_mask = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("empty valid", 32'(out_valid), 32'd0);
    check("empty ready", 32'(in_ready),  32'd1);
    check("empty done",  32'(done),      32'd1);
    tick();
    check("empty valid2", 32'(out_valid), 32'd0);
    check("empty done2",  32'(done),      32'd0);

    // Back-to-back: frame 2 offered throughout frame 1
    load_ramp(); in_mask = 8'hFF; in_valid = 1'b1;
    tick();
    in_data = '0; in_data[15:0] = 16'hBEEF; in_mask = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      #1;
      check("b2b in_ready", 32'(in_ready), 32'(k == 8));
      check("b2b ch", 32'(out_ch), 32'(k));
      tick();
    end
    in_valid = 1'b0;
    check("b2b valid", 32'(out_valid), 32'd1);
    check("b2b ch2",   32'(out_ch),    32'd1);
    check("b2b data",  32'(out_data),  32'hBEEF);
    check("b2b last",  32'(out_last),  32'd1);
    check("b2b done1", 32'(done),      32'd1);
    tick();
    check("b2b idle",  32'(out_valid), 32'd0);
    check("b2b done2", 32'(done),      32'd1);
    tick();
    check("b2b done3", 32'(done),      32'd0);

    // Reset in the middle of a frame
    load_ramp(); in_mask = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check("mid ch", 32'(out_ch), 32'(k));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst valid", 32'(out_valid), 32'd0);
    check("mid rst ch",    32'(out_ch),    32'd0);
    check("mid rst done",  32'(done),      32'd0);
    check("mid rst ready", 32'(in_ready),  32'd1);
    for (int k = 0; k < 4; k++) begin
      check("mid quiet", 32'(out_valid), 32'd0);
      tick();
    end

    // 5-lane, 12-bit instance
    for (int k = 1; k <= 5; k++) in_data5[(k-1)*12 +: 12] = 12'(k * 12'h111);
    in_mask5 = 5'h1F; in_valid5 = 1'b1; out_ready5 = 1'b1;
    tick();
    in_valid5 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check("n5 valid", 32'(out_valid5), 32'd1);
      check("n5 ch",    32'(out_ch5),    32'(k));
      check("n5 data",  32'(out_data5),  32'(k * 12'h111));
      check("n5 last",  32'(out_last5),  32'(k == 5));
      tick();
    end
    check("n5 end valid", 32'(out_valid5), 32'd0);
    check("n5 done",      32'(done5),      32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fc_lane_serializer.md
Name: fc_lane_serializer

Overview:
- Captures NUM_CH parallel result lanes from the fully-connected PE array in one transfer.
- Emits the enabled lanes one per accepted beat on a single valid/ready stream, tagged with a 1-based channel index.
- Channel numbering is 1..NUM_CH; 0 means "no channel", the same convention as the existing lane-select muxes.
- Replaces fixed 8:1 select muxing with a parametrised, handshaked, mask-aware sequencer.

Parameters:
- DATA_WIDTH, 16, width of one lane.
- NUM_CH, 8, number of input lanes; legal range 2..32.
- CH_W, $clog2(NUM_CH+1), width of the channel tag. Derived; must not be overridden.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  NUM_CH*DATA_WIDTH  packed lanes; lane k (1-based) occupies bits [k*DATA_WIDTH-1 : (k-1)*DATA_WIDTH].
- in_mask  input  NUM_CH  lane enables; bit k-1 enables lane k. Captured with in_data.
- in_valid  input  1  in_data and in_mask are valid.
- in_ready  output  1  block can accept a frame.
- out_data  output  DATA_WIDTH  current lane value.
- out_ch  output  CH_W  1-based index of the current lane; 0 when out_valid=0.
- out_last  output  1  current beat is the final enabled lane of the frame.
- out_valid  output  1  out_data, out_ch and out_last are valid.
- out_ready  input  1  downstream accepts the beat.
- done  output  1  one-cycle pulse after a frame completes.

Behaviour:
- Reset:
  - Synchronous: state and all registers are updated only on a clk edge with rst=1.
  - rst has priority over any handshake sampled in the same cycle.
  - After the reset edge: state=IDLE, out_valid=0, out_data=0, out_ch=0, out_last=0, done=0, holding regs=0, in_ready=1.
  - A reset in SEND discards the frame with no further beats.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SEND: out_valid=1.
- Accept: a frame is accepted when in_valid & in_ready at an edge.
  - On accept, capture in_data into the holding register and in_mask into the remaining-mask register rem.
- IDLE accept with in_mask != 0: go to SEND. The first beat is visible the next cycle (latency 1).
- IDLE accept with in_mask == 0: stay in IDLE, emit no beats, assert done for 1 cycle in the following cycle.
- SEND outputs, all derived from rem and the holding register:
  - Current lane c = lowest set bit of rem (1-based).
  - out_ch=c; out_data=lane c.
  - out_last=1 iff rem has exactly one bit set.
- Stall: while out_valid & !out_ready, out_data, out_ch and out_last hold stable.
- Beat accepted (out_valid & out_ready): clear bit c in rem.
  - If out_last=0: stay in SEND.
  - If out_last=1: the frame is complete; done=1 in the next cycle.
- Back-to-back frames:
  - In SEND, in_ready = out_valid & out_ready & out_last (combinational).
  - If a new frame is accepted on the final beat, reload the holding register and rem, and stay in SEND if the new mask != 0. No idle bubble.
  - done still pulses for the completed frame.
  - Otherwise go to IDLE after the final beat.
- Ordering: lanes are emitted in ascending index order; disabled lanes are skipped with no bubble cycles.
- in_data and in_mask are ignored when not accepted; changes to them during SEND have no effect.
- done and out_valid may be high in the same cycle (back-to-back case).
- No arithmetic on data: lanes pass through bit-exact.
- Lane selection is an indexed mux over NUM_CH lanes, not a fixed case list.

Test Plan:
- Reset, then frame with NUM_CH=8, lanes k=0x0k00, mask=0xFF, out_ready=1:
  - Beats on 8 consecutive cycles starting 1 cycle after accept.
  - out_ch=1..8, out_data=0x0100..0x0800, out_last only with out_ch=8, done 1 cycle after it.
- mask=0b1010_0100, out_ready toggling 1,0,1,0:
  - Exactly 3 beats: out_ch=3,6,8.
  - Values stable across stall cycles; out_last with ch 8 only.
- mask=0x00:
  - No out_valid; in_ready stays 1; done pulses the cycle after accept.
- Back-to-back: second frame (mask=0x01, lane1=0xBEEF) presented with in_valid held through frame 1:
  - Accepted exactly on frame 1's last beat.
  - Next cycle out_ch=1, out_data=0xBEEF, out_last=1.
  - done pulses concurrently with that beat.
- rst=1 mid-frame after 3 of 8 beats:
  - Next cycle out_valid=0, out_ch=0, done=0, in_ready=1.
  - No further beats from the old frame.
- NUM_CH=5, DATA_WIDTH=12 build, mask=0x1F: CH_W=3; beats out_ch=1..5 with correct 12-bit lanes.
